aurora_hls_nfc_controller: RTL and testbench

- Sequences Aurora native flow control (NFC) for the receive path.
- Compares the RX FIFO fill level against the programmed fifo_thresholds word.
- Issues XOFF/XON requests to the Aurora core over an AXI-Stream-style NFC handshake, with hysteresis between the two thresholds.
- Sits between the RX FIFO occupancy counter, the static configuration block and the Aurora core's s_axi_nfc port; optionally keeps pause statistics.

---
 rtl/aurora_hls_nfc_controller.sv | 205 ++++++++++++++++++++
 tb/tb_aurora_hls_nfc_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_hls_nfc_controller.sv
// aurora_hls_nfc_controller
// Aurora native flow control (NFC) sequencer for the receive path.
// The RX FIFO fill level is compared against the XOFF/XON thresholds, with
// hysteresis between them. XOFF/XON requests go to the core over a
// valid/ready handshake, and at most one request is outstanding at a time.
// Optional feature macro: AURORA_HLS_NFC_STATS_EN. When it is defined, the
// block keeps saturating xoff_count and pause_cycles counters. When it is
// undefined, no counter registers exist and both outputs are tied to zero.
module aurora_hls_nfc_controller #(
    parameter int FILL_WIDTH = 16,
    parameter int NFC_WIDTH  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  channel_up,
    input  logic [31:0]           fifo_thresholds,
    input  logic [FILL_WIDTH-1:0] rx_fill_level,
    output logic                  nfc_tvalid,
    input  logic                  nfc_tready,
    output logic [NFC_WIDTH-1:0]  nfc_tdata,
    output logic                  paused,
    output logic [31:0]           xoff_count,
    output logic [31:0]           pause_cycles
);

    typedef enum logic [1:0] {
        ST_FLOWING   = 2'd0,
        ST_SEND_XOFF = 2'd1,
        ST_PAUSED    = 2'd2,
        ST_SEND_XON  = 2'd3
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [FILL_WIDTH-1:0] fill_q;
    logic [FILL_WIDTH-1:0] xoff_th_q;
    logic [FILL_WIDTH-1:0] xon_th_q;
    logic                  enabled_s;
    logic                  tvalid_q;
    logic                  tvalid_d;
    logic                  xoff_bit_q;
    logic                  xoff_bit_d;
    logic                  paused_q;
    logic                  paused_d;

    // Thresholds must be non-zero and correctly ordered before any request
    // is allowed; otherwise the hysteresis band is meaningless.
    assign enabled_s = (xoff_th_q != {FILL_WIDTH{1'b0}}) && (xon_th_q < xoff_th_q);

    // Sample the fill level and the threshold fields.
    // This register stage sets the fill-to-request latency.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            fill_q    <= {FILL_WIDTH{1'b0}};
            xoff_th_q <= {FILL_WIDTH{1'b0}};
            xon_th_q  <= {FILL_WIDTH{1'b0}};
        end else begin
            fill_q    <= rx_fill_level;
            xoff_th_q <= fifo_thresholds[16 +: FILL_WIDTH];
            xon_th_q  <= fifo_thresholds[0 +: FILL_WIDTH];
        end
    end

    // FSM state register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_FLOWING;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. When the link is down, any pending request is dropped.
    // When a request is pending, it is held until the core accepts it.
    always_comb begin
        state_d = state_q;
        if (!channel_up) begin
            state_d = ST_FLOWING;
        end else begin
            case (state_q)
                ST_FLOWING: begin
                    if (enabled_s && (fill_q >= xoff_th_q)) begin
                        state_d = ST_SEND_XOFF;
                    end else begin
                        state_d = ST_FLOWING;
                    end
                end
                ST_SEND_XOFF: begin
                    if (nfc_tready) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_SEND_XOFF;
                    end
                end
                ST_PAUSED: begin
                    if (!enabled_s) begin
                        state_d = ST_FLOWING;
                    end else if (fill_q <= xon_th_q) begin
                        state_d = ST_SEND_XON;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_SEND_XON: begin
                    if (nfc_tready) begin
                        state_d = ST_FLOWING;
                    end else begin
                        state_d = ST_SEND_XON;
                    end
                end
                default: begin
                    state_d = ST_FLOWING;
                end
            endcase
        end
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state register.
    always_comb begin
        tvalid_d   = 1'b0;
        xoff_bit_d = 1'b0;
        paused_d   = 1'b0;
        case (state_d)
            ST_FLOWING: begin
                tvalid_d   = 1'b0;
                xoff_bit_d = 1'b0;
                paused_d   = 1'b0;
            end
            ST_SEND_XOFF: begin
                tvalid_d   = 1'b1;
                xoff_bit_d = 1'b1;
                paused_d   = 1'b0;
            end
            ST_PAUSED: begin
                tvalid_d   = 1'b0;
                xoff_bit_d = 1'b0;
                paused_d   = 1'b1;
            end
            ST_SEND_XON: begin
                tvalid_d   = 1'b1;
                xoff_bit_d = 1'b0;
                paused_d   = 1'b1;
            end
            default: begin
                tvalid_d   = 1'b0;
                xoff_bit_d = 1'b0;
                paused_d   = 1'b0;
            end
        endcase
    end

    // Registered handshake and status outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            tvalid_q   <= 1'b0;
            xoff_bit_q <= 1'b0;
            paused_q   <= 1'b0;
        end else begin
            tvalid_q   <= tvalid_d;
            xoff_bit_q <= xoff_bit_d;
            paused_q   <= paused_d;
        end
    end

    assign nfc_tvalid = tvalid_q;
    assign nfc_tdata  = {{(NFC_WIDTH-1){1'b0}}, xoff_bit_q};
    assign paused     = paused_q;

`ifdef AURORA_HLS_NFC_STATS_EN
    logic [31:0] xoff_count_q;
    logic [31:0] pause_cycles_q;
    logic        xoff_accept_s;

    // An XOFF is counted only when the core accepts it with the link up.
    // A request that is dropped by a link drop is not counted.
    assign xoff_accept_s = (state_q == ST_SEND_XOFF) && channel_up && nfc_tready;

    // Saturating pause statistics. Link drops leave the counters unchanged.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            xoff_count_q   <= 32'd0;
            pause_cycles_q <= 32'd0;
        end else begin
            if (xoff_accept_s && (xoff_count_q != 32'hFFFF_FFFF)) begin
                xoff_count_q <= xoff_count_q + 32'd1;
            end else begin
                xoff_count_q <= xoff_count_q;
            end
            if (paused_q && (pause_cycles_q != 32'hFFFF_FFFF)) begin
                pause_cycles_q <= pause_cycles_q + 32'd1;
            end else begin
                pause_cycles_q <= pause_cycles_q;
            end
        end
    end

    assign xoff_count   = xoff_count_q;
    assign pause_cycles = pause_cycles_q;
`else
    assign xoff_count   = 32'd0;
    assign pause_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_aurora_hls_nfc_controller.sv
// tb_aurora_hls_nfc_controller
// Directed self-checking bench for aurora_hls_nfc_controller. The expected
// counter values depend on whether AURORA_HLS_NFC_STATS_EN is defined.
module tb_aurora_hls_nfc_controller;

`ifdef AURORA_HLS_NFC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        ap_clk;
    logic        ap_rst_n;
    logic        channel_up;
    logic [31:0] fifo_thresholds;
    logic [15:0] rx_fill_level;
    logic        nfc_tvalid;
    logic        nfc_tready;
    logic [15:0] nfc_tdata;
    logic        paused;
    logic [31:0] xoff_count;
    logic [31:0] pause_cycles;

    int n_checks;
    int n_errors;

    aurora_hls_nfc_controller #(
        .FILL_WIDTH(16),
        .NFC_WIDTH (16)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .channel_up     (channel_up),
        .fifo_thresholds(fifo_thresholds),
        .rx_fill_level  (rx_fill_level),
        .nfc_tvalid     (nfc_tvalid),
        .nfc_tready     (nfc_tready),
        .nfc_tdata      (nfc_tdata),
        .paused         (paused),
        .xoff_count     (xoff_count),
        .pause_cycles   (pause_cycles)
    );

    // 100 MHz kernel clock.
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        tick(2);
        ap_rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        ap_rst_n        = 1'b0;
        channel_up      = 1'b0;
        fifo_thresholds = 32'h00C0_0040;
        rx_fill_level   = 16'h0000;
        nfc_tready      = 1'b1;
        do_reset();

        // Reset state
        check_eq("rst_tvalid", {31'd0, nfc_tvalid}, 32'd0);
        check_eq("rst_tdata", {16'd0, nfc_tdata}, 32'd0);
        check_eq("rst_paused", {31'd0, paused}, 32'd0);
        check_eq("rst_xoff_count", xoff_count, 32'd0);
        check_eq("rst_pause_cycles", pause_cycles, 32'd0);

        // XOFF/XON cycle
        channel_up = 1'b1;
        tick(3);
        for (int f = 0; f <= 16'hB0; f += 16'h10) begin
            rx_fill_level = f[15:0];
            tick(1);
            check_eq("ramp_up_no_req", {31'd0, nfc_tvalid}, 32'd0);
        end
        rx_fill_level = 16'h00C0;
        tick(1);
        check_eq("xoff_latency_1", {31'd0, nfc_tvalid}, 32'd0);
        tick(1);
        check_eq("xoff_valid", {31'd0, nfc_tvalid}, 32'd1);
        check_eq("xoff_tdata", {16'd0, nfc_tdata}, 32'h0000_0001);
        check_eq("xoff_not_paused_yet", {31'd0, paused}, 32'd0);
        tick(1);
        check_eq("xoff_accepted_tvalid", {31'd0, nfc_tvalid}, 32'd0);
        check_eq("xoff_accepted_paused", {31'd0, paused}, 32'd1);
        check_eq("xoff_count_1", xoff_count, STATS ? 32'd1 : 32'd0);
        tick(3);
        check_eq("hold_paused", {31'd0, paused}, 32'd1);
        for (int f = 16'hB0; f >= 16'h50; f -= 16'h10) begin
            rx_fill_level = f[15:0];
            tick(1);
            check_eq("ramp_down_no_req", {31'd0, nfc_tvalid}, 32'd0);
        end
        rx_fill_level = 16'h0040;
        tick(2);
        check_eq("xon_valid", {31'd0, nfc_tvalid}, 32'd1);
        check_eq("xon_tdata", {16'd0, nfc_tdata}, 32'h0000_0000);
        check_eq("xon_still_paused", {31'd0, paused}, 32'd1);
        tick(1);
        check_eq("xon_accepted_tvalid", {31'd0, nfc_tvalid}, 32'd0);
        check_eq("xon_accepted_paused", {31'd0, paused}, 32'd0);
        check_eq("xoff_count_after_xon", xoff_count, STATS ? 32'd1 : 32'd0);
        check_eq("pause_cycles_13", pause_cycles, STATS ? 32'd13 : 32'd0);

        // Backpressure: XOFF held for 10 cycles while the fill drops
        nfc_tready    = 1'b0;
        rx_fill_level = 16'h00C0;
        tick(2);
        check_eq("bp_xoff_valid", {31'd0, nfc_tvalid}, 32'd1);
        rx_fill_level = 16'h0010;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_eq("bp_hold_tvalid", {31'd0, nfc_tvalid}, 32'd1);
            check_eq("bp_hold_tdata", {16'd0, nfc_tdata}, 32'h0000_0001);
            check_eq("bp_hold_paused", {31'd0, paused}, 32'd0);
        end
        nfc_tready = 1'b1;
        tick(1);
        check_eq("bp_accept_paused", {31'd0, paused}, 32'd1);
        check_eq("bp_accept_tvalid", {31'd0, nfc_tvalid}, 32'd0);
        check_eq("bp_xoff_count_2", xoff_count, STATS ? 32'd2 : 32'd0);
        tick(1);
        check_eq("bp_xon_valid", {31'd0, nfc_tvalid}, 32'd1);
        check_eq("bp_xon_tdata", {16'd0, nfc_tdata}, 32'h0000_0000);
        tick(1);
        check_eq("bp_xon_done_paused", {31'd0, paused}, 32'd0);
        check_eq("bp_pause_cycles_15", pause_cycles, STATS ? 32'd15 : 32'd0);

        // Hysteresis from a fresh reset
        do_reset();
        channel_up = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx_fill_level = i[0] ? 16'h00BF : 16'h0050;
            tick(1);
            check_eq("hyst_no_req", {31'd0, nfc_tvalid}, 32'd0);
        end
        check_eq("hyst_xoff_count", xoff_count, 32'd0);

        // Disabled configurations
        fifo_thresholds = 32'h0000_0040;
        rx_fill_level   = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check_eq("dis0_no_req", {31'd0, nfc_tvalid}, 32'd0);
            check_eq("dis0_paused", {31'd0, paused}, 32'd0);
        end
        fifo_thresholds = 32'h0040_0080;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check_eq("dis1_no_req", {31'd0, nfc_tvalid}, 32'd0);
            check_eq("dis1_paused", {31'd0, paused}, 32'd0);
        end

        // Link drop during SEND_XOFF
        fifo_thresholds = 32'h00C0_0040;
        rx_fill_level   = 16'h0000;
        tick(2);
        nfc_tready    = 1'b0;
        rx_fill_level = 16'h00C0;
        tick(2);
        check_eq("ld_xoff_valid", {31'd0, nfc_tvalid}, 32'd1);
        channel_up = 1'b0;
        tick(1);
        check_eq("ld_drop_tvalid", {31'd0, nfc_tvalid}, 32'd0);
        check_eq("ld_drop_paused", {31'd0, paused}, 32'd0);
        rx_fill_level = 16'h00D0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check_eq("ld_down_tvalid", {31'd0, nfc_tvalid}, 32'd0);
        end
        check_eq("ld_no_count", xoff_count, 32'd0);
        channel_up = 1'b1;
        tick(1);
        check_eq("ld_fresh_xoff", {31'd0, nfc_tvalid}, 32'd1);
        check_eq("ld_fresh_tdata", {16'd0, nfc_tdata}, 32'h0000_0001);
        nfc_tready = 1'b1;
        tick(1);
        check_eq("ld_paused", {31'd0, paused}, 32'd1);
        check_eq("ld_xoff_count_1", xoff_count, STATS ? 32'd1 : 32'd0);

        // Asynchronous reset mid-PAUSED, between clock edges
        tick(2);
        check_eq("ar_pre_paused", {31'd0, paused}, 32'd1);
        #3;
        ap_rst_n = 1'b0;
        #1;
        check_eq("ar_tvalid", {31'd0, nfc_tvalid}, 32'd0);
        check_eq("ar_tdata", {16'd0, nfc_tdata}, 32'd0);
        check_eq("ar_paused", {31'd0, paused}, 32'd0);
        check_eq("ar_xoff_count", xoff_count, 32'd0);
        check_eq("ar_pause_cycles", pause_cycles, 32'd0);
        tick(1);
        ap_rst_n = 1'b1;
        tick(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
